// File: rtl/dual_port_fake_tx.sv
// Self-running fake frame source on a 64-bit AXI-Stream master (no tready).
// Optional single-shot mode: define DUAL_PORT_FAKE_TX_SINGLE_SHOT_EN to stop after NUM_FRAMES frames.
//
// state | meaning
// WAIT  | idle after reset, counting START_DELAY cycles
// SEND  | one beat per cycle until the frame's tlast beat
// GAP   | GAP_CYCLES idle cycles between frames
// DONE  | single-shot only: all frames sent, outputs held at 0 until reset
module dual_port_fake_tx #(
  parameter int unsigned FRAME_BEATS = 8,
  parameter int unsigned GAP_CYCLES  = 4,
  parameter int unsigned START_DELAY = 2,
  parameter logic [7:0]  LAST_KEEP   = 8'h0F,
  parameter int unsigned NUM_FRAMES  = 3
) (
  input  logic        i_clk,
  input  logic        i_reset,
  output logic        o_transmit_fake_flag,
  output logic        o_tx_axis_tvalid,
  output logic [63:0] o_tx_axis_tdata,
  output logic        o_tx_axis_tlast,
  output logic [7:0]  o_tx_axis_tkeep
);

`ifdef DUAL_PORT_FAKE_TX_SINGLE_SHOT_EN
  typedef enum logic [1:0] {ST_WAIT, ST_SEND, ST_GAP, ST_DONE} state_t;
  localparam logic [15:0] LAST_FRAME = 16'(NUM_FRAMES - 1);
`else
  typedef enum logic [1:0] {ST_WAIT, ST_SEND, ST_GAP} state_t;
`endif

  localparam logic [15:0] LAST_IDX = 16'(FRAME_BEATS - 1);
  localparam logic [31:0] DELAY_TC = 32'(START_DELAY);
  localparam logic [31:0] GAP_LOAD = 32'(GAP_CYCLES - 1);

  state_t      state;
  state_t      state_after_last;
  logic [31:0] delay_cnt;
  logic [31:0] gap_cnt;
  logic [15:0] beat_idx;
  logic [15:0] frame_cnt;
  logic        emit;
  logic        beat_last;

  // emit: the coming edge registers a beat (first beat leaves WAIT directly)
  always_comb begin
    emit      = (state == ST_SEND) || ((state == ST_WAIT) && (delay_cnt == DELAY_TC));
    beat_last = (beat_idx == LAST_IDX);
    state_after_last = (GAP_CYCLES == 0) ? ST_SEND : ST_GAP;
`ifdef DUAL_PORT_FAKE_TX_SINGLE_SHOT_EN
    if (frame_cnt == LAST_FRAME) state_after_last = ST_DONE;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state                <= ST_WAIT;
      delay_cnt            <= '0;
      gap_cnt              <= '0;
      beat_idx             <= '0;
      frame_cnt            <= '0;
      o_transmit_fake_flag <= 1'b0;
      o_tx_axis_tvalid     <= 1'b0;
      o_tx_axis_tdata      <= '0;
      o_tx_axis_tlast      <= 1'b0;
      o_tx_axis_tkeep      <= '0;
    end else begin
      o_transmit_fake_flag <= 1'b0;
      o_tx_axis_tvalid     <= 1'b0;
      o_tx_axis_tdata      <= '0;
      o_tx_axis_tlast      <= 1'b0;
      o_tx_axis_tkeep      <= '0;
      if (emit) begin
        o_transmit_fake_flag <= (beat_idx == 16'd0);
        o_tx_axis_tvalid     <= 1'b1;
        o_tx_axis_tdata      <= {16'hFA4E, frame_cnt, 16'h0000, beat_idx};
        o_tx_axis_tlast      <= beat_last;
        o_tx_axis_tkeep      <= beat_last ? LAST_KEEP : 8'hFF;
        if (beat_last) begin
          beat_idx  <= '0;
          frame_cnt <= frame_cnt + 16'd1;
          gap_cnt   <= GAP_LOAD;
          state     <= state_after_last;
        end else begin
          beat_idx <= beat_idx + 16'd1;
          state    <= ST_SEND;
        end
      end else begin
        case (state)
          ST_WAIT: delay_cnt <= delay_cnt + 32'd1;
          ST_GAP: begin
            if (gap_cnt == 32'd0) state <= ST_SEND;
            else                  gap_cnt <= gap_cnt - 32'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dual_port_fake_tx.sv
// Directed bench for dual_port_fake_tx: default instance plus a 1-beat, no-gap instance.
module tb_dual_port_fake_tx;

  logic        clk;
  logic        rst;
  logic        flag,  tvalid,  tlast;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        b_flag, b_tvalid, b_tlast;
  logic [63:0] b_tdata;
  logic [7:0]  b_tkeep;

  int n_vec = 0;
  int n_err = 0;

  dual_port_fake_tx u_dut (
    .i_clk                (clk),
    .i_reset              (rst),
    .o_transmit_fake_flag (flag),
    .o_tx_axis_tvalid     (tvalid),
    .o_tx_axis_tdata      (tdata),
    .o_tx_axis_tlast      (tlast),
    .o_tx_axis_tkeep      (tkeep)
  );

  dual_port_fake_tx #(
    .FRAME_BEATS (1),
    .GAP_CYCLES  (0),
    .START_DELAY (0),
    .LAST_KEEP   (8'h01)
  ) u_b2b (
    .i_clk                (clk),
    .i_reset              (rst),
    .o_transmit_fake_flag (b_flag),
    .o_tx_axis_tvalid     (b_tvalid),
    .o_tx_axis_tdata      (b_tdata),
    .o_tx_axis_tlast      (b_tlast),
    .o_tx_axis_tkeep      (b_tkeep)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_main(input string tag, input logic v, input logic [63:0] d,
                            input logic f, input logic l, input logic [7:0] k);
    check({tag, ".tvalid"}, 64'(tvalid), 64'(v));
    check({tag, ".tdata"},  tdata,       d);
    check({tag, ".flag"},   64'(flag),   64'(f));
    check({tag, ".tlast"},  64'(tlast),  64'(l));
    check({tag, ".tkeep"},  64'(tkeep),  64'(k));
  endtask

  initial begin
    int flag_cnt;
    int last_cnt;
    int viol;
    int late_valid;
    logic [63:0] exp_d;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_main("reset", 1'b0, 64'h0, 1'b0, 1'b0, 8'h00);
    check("b2b_reset.tvalid", 64'(b_tvalid), 64'h0);

    rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k < 3) check_main($sformatf("start_idle%0d", k), 1'b0, 64'h0, 1'b0, 1'b0, 8'h00);
      else       check_main("f0b0", 1'b1, 64'hFA4E_0000_0000_0000, 1'b1, 1'b0, 8'hFF);
      exp_d = 64'hFA4E_0000_0000_0000 | (64'(k - 1) << 32);
      check($sformatf("b2b%0d.tdata", k), b_tdata, exp_d);
      check($sformatf("b2b%0d.flags", k), 64'({b_tvalid, b_flag, b_tlast}), 64'h7);
      check($sformatf("b2b%0d.tkeep", k), 64'(b_tkeep), 64'h01);
    end

    for (int b = 1; b <= 7; b++) begin
      @(negedge clk);
      exp_d = 64'hFA4E_0000_0000_0000 | 64'(b);
      check_main($sformatf("f0b%0d", b), 1'b1, exp_d, 1'b0, (b == 7), (b == 7) ? 8'h0F : 8'hFF);
    end

    for (int g = 0; g < 4; g++) begin
      @(negedge clk);
      check_main($sformatf("gap%0d", g), 1'b0, 64'h0, 1'b0, 1'b0, 8'h00);
    end

    for (int b = 0; b <= 3; b++) begin
      @(negedge clk);
      exp_d = 64'hFA4E_0001_0000_0000 | 64'(b);
      check_main($sformatf("f1b%0d", b), 1'b1, exp_d, (b == 0), 1'b0, 8'hFF);
    end

    rst = 1'b1;
    @(negedge clk);
    check_main("abort", 1'b0, 64'h0, 1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("restart_idle.tvalid", 64'(tvalid), 64'h0);
    end
    @(negedge clk);
    check_main("restart_f0b0", 1'b1, 64'hFA4E_0000_0000_0000, 1'b1, 1'b0, 8'hFF);

    flag_cnt   = 0;
    last_cnt   = 0;
    viol       = 0;
    late_valid = 0;
    for (int c = 1; c <= 1000; c++) begin
      @(negedge clk);
      if (flag)  flag_cnt++;
      if (tlast) last_cnt++;
      if (!tvalid && (tkeep != 8'h00 || flag || tlast || tdata != 64'h0)) viol++;
      if (c > 900 && tvalid) late_valid++;
    end
    check("run.idle_clean", 64'(viol), 64'h0);
`ifdef DUAL_PORT_FAKE_TX_SINGLE_SHOT_EN
    check("run.tlast_cnt",  64'(last_cnt),   64'd3);
    check("run.flag_cnt",   64'(flag_cnt),   64'd2);
    check("run.done_quiet", 64'(late_valid), 64'd0);
`else
    check("run.tlast_cnt",  64'(last_cnt),   64'd83);
    check("run.flag_cnt",   64'(flag_cnt),   64'd83);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
